// File: rtl/sv39_page_walker.sv
// Sv39 page-table walker for instruction fetch: reads PTEs with 8-beat Sysbus line
// reads, walks up to three levels and returns a physical address or a page fault.
module sv39_page_walker #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int PTESIZE        = 8,
    parameter int LEVELS         = 3,
    parameter int BEATS_PER_LINE = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      walk_req_valid,
    input  logic [63:0]               walk_req_vaddr,
    input  logic [63:0]               walk_ptbr,
    output logic                      walk_req_ready,
    output logic                      walk_resp_valid,
    output logic [63:0]               walk_resp_paddr,
    output logic                      walk_resp_fault,
    input  logic                      walk_resp_ack,
    output logic                      bus_reqcyc,
    output logic [63:0]               bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_reqack,
    input  logic                      bus_respcyc,
    output logic                      bus_respack,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag
);
    localparam int PTE_LSB  = $clog2(PTESIZE);
    localparam int LINE_LSB = $clog2(PTESIZE * BEATS_PER_LINE);
    localparam int BEAT_W   = $clog2(BEATS_PER_LINE);
    localparam int LVL_W    = $clog2(LEVELS);
    localparam logic [LVL_W-1:0]  LAST_LVL  = LVL_W'(LEVELS - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS_PER_LINE - 1);
    localparam logic       SYSBUS_READ   = 1'b1;
    localparam logic [3:0] SYSBUS_MEMORY = 4'b0001;

    typedef enum logic [2:0] {IDLE, REQ, RESP, EVAL, DONE} state_t;

    state_t                    state_q, state_d;
    logic [38:0]               va_q;
    logic [63:0]               a_q;
    logic [LVL_W-1:0]          lvl_q;
    logic [BEAT_W-1:0]         beat_q;
    logic [BUS_DATA_WIDTH-1:0] pte_q;
    logic [63:0]               paddr_q;
    logic                      fault_q;

    logic [8:0]  vpn;
    logic [63:0] pte_addr;
    logic [43:0] ppn;
    logic        eval_leaf, eval_misaligned, eval_fault;
    logic [63:0] leaf_paddr;
    logic        unused_bits;

    always_comb begin
        vpn = 9'd0;
        case (lvl_q)
            LVL_W'(0): vpn = va_q[38:30];
            LVL_W'(1): vpn = va_q[29:21];
            default:   vpn = va_q[20:12];
        endcase
    end

    assign pte_addr   = a_q + (64'(vpn) << PTE_LSB);
    assign bus_req    = bus_reqcyc ? {pte_addr[63:LINE_LSB], LINE_LSB'(0)} : 64'd0;
    assign bus_reqtag = BUS_TAG_WIDTH'({SYSBUS_READ, SYSBUS_MEMORY, 8'h00});
    assign ppn        = pte_q[53:10];

    // PTE bits: [0]=V [1]=R [2]=W [3]=X; superpages must have their low PPN bits clear.
    always_comb begin
        eval_leaf       = pte_q[1] | pte_q[3];
        eval_misaligned = eval_leaf &&
                          ((lvl_q == LVL_W'(0) && ppn[17:0] != 18'd0) ||
                           (lvl_q == LVL_W'(1) && ppn[8:0]  != 9'd0));
        eval_fault      = !pte_q[0] || (!pte_q[1] && pte_q[2]) ||
                          (lvl_q == LAST_LVL && !eval_leaf) || eval_misaligned;
    end

    always_comb begin
        leaf_paddr = 64'd0;
        case (lvl_q)
            LVL_W'(0): leaf_paddr = {8'd0, ppn[43:18], va_q[29:0]};
            LVL_W'(1): leaf_paddr = {8'd0, ppn[43:9],  va_q[20:0]};
            default:   leaf_paddr = {8'd0, ppn,        va_q[11:0]};
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        // NOTE: every output and the next state get a default first so no latch is inferred.
        state_d         = state_q;
        walk_req_ready  = 1'b0;
        walk_resp_valid = 1'b0;
        bus_reqcyc      = 1'b0;
        bus_respack     = 1'b0;
        case (state_q)
            IDLE: begin
                walk_req_ready = 1'b1;
                if (walk_req_valid) state_d = REQ;
            end
            REQ: begin
                bus_reqcyc = 1'b1;
                if (bus_reqack) state_d = RESP;
            end
            RESP: begin
                bus_respack = bus_respcyc;
                if (bus_respcyc && beat_q == LAST_BEAT) state_d = EVAL;
            end
            EVAL: state_d = (eval_fault || eval_leaf) ? DONE : REQ;
            DONE: begin
                walk_resp_valid = 1'b1;
                if (walk_resp_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The whole line is always drained; only the beat holding our PTE is kept.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register updates from pre-edge values.
        if (reset) begin
            va_q    <= '0;
            a_q     <= '0;
            lvl_q   <= '0;
            beat_q  <= '0;
            pte_q   <= '0;
            paddr_q <= '0;
            fault_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (walk_req_valid) begin
                    va_q  <= walk_req_vaddr[38:0];
                    a_q   <= walk_ptbr;
                    lvl_q <= '0;
                end
                REQ: beat_q <= '0;
                RESP: if (bus_respcyc) begin
                    beat_q <= beat_q + BEAT_W'(1);
                    if (beat_q == pte_addr[LINE_LSB-1:PTE_LSB]) pte_q <= bus_resp;
                end
                EVAL: begin
                    if (eval_fault) begin
                        paddr_q <= '0;
                        fault_q <= 1'b1;
                    end else if (eval_leaf) begin
                        paddr_q <= leaf_paddr;
                        fault_q <= 1'b0;
                    end else begin
                        a_q   <= {8'd0, ppn, 12'd0};
                        lvl_q <= lvl_q + LVL_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign walk_resp_paddr = paddr_q;
    assign walk_resp_fault = fault_q;

    assign unused_bits = ^{bus_resptag, walk_req_vaddr[63:39], pte_q[BUS_DATA_WIDTH-1:54],
                           pte_q[9:4], pte_addr[PTE_LSB-1:0]};
endmodule
